div_seq_32: RTL and testbench

- Multicycle 32-bit unsigned restoring divider.
- Time-shares one RC_ADD_SUB_32 instance, hardwired to subtract, across 32 iterations.
- Sits beside the ALU. The control unit issues START with operands, waits for DONE, then reads QUO/REM.
- Replaces a large combinational divider with one adder, a 6-bit counter and a 3-state FSM.

---
 rtl/div_seq_32_pkg.sv | 19 +
 rtl/div_seq_32_if.sv | 23 ++
 rtl/div_seq_32_rc_add_sub.sv | 35 +++
 rtl/div_seq_32.sv | 122 ++++++++++++
 tb/tb_div_seq_32.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_seq_32_pkg.sv
// Shared constants and the FSM state type for the sequential divider.
package div_seq_32_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ITER       = DATA_WIDTH;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } div_state_t;

    // Quotient reported for a zero divisor: all ones.
    function automatic logic [DATA_WIDTH-1:0] dbz_quotient();
        return '1;
    endfunction

endpackage

// File: rtl/div_seq_32_if.sv
// Control-unit side handshake and result bus of the divider.
interface div_seq_32_if;
    import div_seq_32_pkg::*;

    logic                  START;
    logic [DATA_WIDTH-1:0] DIVIDEND;
    logic [DATA_WIDTH-1:0] DIVISOR;
    logic [DATA_WIDTH-1:0] QUO;
    logic [DATA_WIDTH-1:0] REM;
    logic                  BUSY;
    logic                  DONE;
    logic                  DBZ;

    modport master (
        output START, DIVIDEND, DIVISOR,
        input  QUO, REM, BUSY, DONE, DBZ
    );

    modport slave (
        input  START, DIVIDEND, DIVISOR,
        output QUO, REM, BUSY, DONE, DBZ
    );
endinterface

// File: rtl/div_seq_32_rc_add_sub.sv
// 32-bit ripple-carry adder/subtractor. SnA=1 gives A-B with CO=1 meaning
// no borrow; SnA=0 gives A+B with CO as the carry out.
module RC_ADD_SUB_32 (
    output logic [31:0] Y,
    output logic        CO,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        SnA
);
    logic [31:0] w_b;
    logic [32:0] w_c;

    // Two's-complement subtract: invert B and inject SnA as carry in.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_binv
            assign w_b[gi] = B[gi] ^ SnA;
        end
    endgenerate

    // Carry ripple from bit 0 upwards.
    always_comb begin
        w_c[0] = SnA;
        for (int i = 0; i < 32; i++) begin
            w_c[i+1] = (A[i] & w_b[i]) | (A[i] & w_c[i]) | (w_b[i] & w_c[i]);
        end
    end

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sum
            assign Y[gi] = A[gi] ^ w_b[gi] ^ w_c[gi];
        end
    endgenerate

    assign CO = w_c[32];
endmodule

// File: rtl/div_seq_32.sv
// Multicycle 32-bit unsigned restoring divider: one shared subtractor,
// a 6-bit iteration counter and a three-state IDLE/RUN/DONE controller.
module div_seq_32
    import div_seq_32_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    div_seq_32_if.slave   bus
);
    div_state_t            r_state;
    div_state_t            w_state_next;
    logic                  w_accept;
    logic                  w_last;

    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] r_r;
    logic [DATA_WIDTH-1:0] r_d;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_rem;
    logic                  r_dbz;

    logic [DATA_WIDTH-1:0] w_rs;
    logic [DATA_WIDTH-1:0] w_y;
    logic                  w_co;
    logic                  w_ok;
    logic [DATA_WIDTH-1:0] w_r_next;
    logic [DATA_WIDTH-1:0] w_q_next;
    logic                  w_div_zero;

    assign w_div_zero = (bus.DIVISOR == '0);

    // Shift the next dividend bit into the partial remainder.
    assign w_rs = {r_r[DATA_WIDTH-2:0], r_q[DATA_WIDTH-1]};

    RC_ADD_SUB_32 u_sub (
        .Y   (w_y),
        .CO  (w_co),
        .A   (w_rs),
        .B   (r_d),
        .SnA (1'b1)
    );

    // If the old R[31] was set the shifted value is at least 2^32, which
    // exceeds any divisor, so the wrapped 32-bit difference is still correct.
    assign w_ok     = r_r[DATA_WIDTH-1] | w_co;
    assign w_r_next = w_ok ? w_y : w_rs;
    assign w_q_next = {r_q[DATA_WIDTH-2:0], w_ok};

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; START is only honoured in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.START) begin
                    w_accept     = 1'b1;
                    w_state_next = w_div_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_W'(ITER - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result latching.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_q   <= '0;
            r_r   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_q   <= bus.DIVIDEND;
            r_d   <= bus.DIVISOR;
            r_r   <= '0;
            r_cnt <= '0;
            r_dbz <= w_div_zero;
            if (w_div_zero) begin
                r_quo <= dbz_quotient();
                r_rem <= bus.DIVIDEND;
            end
        end else if (r_state == ST_RUN) begin
            r_r   <= w_r_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_quo <= w_q_next;
                r_rem <= w_r_next;
            end
        end
    end

    assign bus.QUO  = r_quo;
    assign bus.REM  = r_rem;
    assign bus.DBZ  = r_dbz;
    assign bus.BUSY = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign bus.DONE = (r_state == ST_DONE);
endmodule

// File: tb/tb_div_seq_32.sv
// Self-checking bench for div_seq_32 using a result scoreboard.
module tb_div_seq_32;
    typedef struct packed {
        logic [31:0] quo;
        logic [31:0] rem;
        logic        dbz;
    } res_t;

    logic clk;
    logic rst_n;
    div_seq_32_if bus();

    div_seq_32 dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    res_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        if (b == 32'd0) begin
            r.quo = 32'hFFFF_FFFF; r.rem = a; r.dbz = 1'b1;
        end else begin
            r.quo = a / b; r.rem = a % b; r.dbz = 1'b0;
        end
        return r;
    endfunction

    // Drive a one-cycle START at the next negedge; returns at the negedge after acceptance.
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input bit push);
        @(negedge clk);
        bus.START = 1'b1; bus.DIVIDEND = a; bus.DIVISOR = b;
        if (push) sb.push_back(model(a, b));
        @(negedge clk);
        bus.START = 1'b0; bus.DIVIDEND = $urandom; bus.DIVISOR = $urandom;
    endtask

    // Wait (bounded) for DONE; lat counts edges from the accepting edge, busy counts BUSY samples.
    task automatic wait_done(input int start_lat, output int lat, output int busy, output bit to);
        lat  = start_lat;
        busy = (bus.BUSY === 1'b1) ? 1 : 0;
        while (bus.DONE !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.BUSY === 1'b1) busy++;
        end
        to = (bus.DONE !== 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.START = 1'b0; bus.DIVIDEND = '0; bus.DIVISOR = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.QUO, bus.REM, bus.BUSY, bus.DONE, bus.DBZ} !== 67'd0)
            $display("FAIL reset_outputs: got quo=%h rem=%h busy=%b done=%b dbz=%b expected all zero",
                     bus.QUO, bus.REM, bus.BUSY, bus.DONE, bus.DBZ);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.BUSY !== 1'b0) $display("FAIL reset_idle: busy=%b expected 0", bus.BUSY);
        else n_pass++;
        $display("reset: checked power-on state");
    endtask

    task automatic test_basic();
        int lat, busy; bit to; res_t e, g;
        drive_start(32'd100, 32'd7, 1'b1);
        wait_done(1, lat, busy, to);
        e = sb.pop_front(); g = '{bus.QUO, bus.REM, bus.DBZ};
        n_checks++;
        if (to || lat != 33) $display("FAIL basic_latency: got %0d timeout=%0b expected 33", lat, to);
        else n_pass++;
        n_checks++;
        if (busy != 33) $display("FAIL basic_busy: got %0d busy cycles expected 33", busy);
        else n_pass++;
        n_checks++;
        if (g !== e) $display("FAIL basic_result: got quo=%h rem=%h dbz=%b expected quo=%h rem=%h dbz=%b",
                              g.quo, g.rem, g.dbz, e.quo, e.rem, e.dbz);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0)
            $display("FAIL basic_done_pulse: done=%b busy=%b expected 0 0", bus.DONE, bus.BUSY);
        else n_pass++;
        $display("basic: 100/7 -> quo=%0d rem=%0d lat=%0d", g.quo, g.rem, lat);
    endtask

    task automatic test_large();
        logic [31:0] av [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bv [2] = '{32'h8000_0001, 32'h0000_0001};
        int lat, busy; bit to; res_t e, g;
        for (int i = 0; i < 2; i++) begin
            drive_start(av[i], bv[i], 1'b1);
            wait_done(1, lat, busy, to);
            e = sb.pop_front(); g = '{bus.QUO, bus.REM, bus.DBZ};
            n_checks++;
            if (to || g !== e)
                $display("FAIL large_result: got quo=%h rem=%h dbz=%b timeout=%0b expected quo=%h rem=%h dbz=%b",
                         g.quo, g.rem, g.dbz, to, e.quo, e.rem, e.dbz);
            else n_pass++;
            $display("large: %h/%h -> quo=%h rem=%h", av[i], bv[i], g.quo, g.rem);
        end
    endtask

    task automatic test_dbz();
        int lat, busy; bit to; res_t e, g;
        drive_start(32'd12345, 32'd0, 1'b1);
        wait_done(1, lat, busy, to);
        e = sb.pop_front(); g = '{bus.QUO, bus.REM, bus.DBZ};
        n_checks++;
        if (to || lat != 1) $display("FAIL dbz_latency: got %0d timeout=%0b expected 1", lat, to);
        else n_pass++;
        n_checks++;
        if (g !== e) $display("FAIL dbz_result: got quo=%h rem=%h dbz=%b expected quo=%h rem=%h dbz=%b",
                              g.quo, g.rem, g.dbz, e.quo, e.rem, e.dbz);
        else n_pass++;
        $display("dbz: 12345/0 -> quo=%h rem=%0d dbz=%b", g.quo, g.rem, g.dbz);
        drive_start(32'd9, 32'd3, 1'b1);
        n_checks++;
        if (bus.DBZ !== 1'b0) $display("FAIL dbz_clear_on_accept: got %b expected 0", bus.DBZ);
        else n_pass++;
        wait_done(1, lat, busy, to);
        e = sb.pop_front(); g = '{bus.QUO, bus.REM, bus.DBZ};
        n_checks++;
        if (to || g !== e) $display("FAIL dbz_next_op: got quo=%h rem=%h dbz=%b expected quo=%h rem=%h dbz=%b",
                                    g.quo, g.rem, g.dbz, e.quo, e.rem, e.dbz);
        else n_pass++;
        $display("dbz: 9/3 -> quo=%0d rem=%0d dbz=%b", g.quo, g.rem, g.dbz);
    endtask

    task automatic test_handshake();
        int lat, busy; bit to; res_t e, g;
        drive_start(32'd100, 32'd7, 1'b1);
        repeat (5) @(negedge clk);
        bus.START = 1'b1; bus.DIVIDEND = 32'd50; bus.DIVISOR = 32'd5;
        @(negedge clk);
        bus.START = 1'b0; bus.DIVIDEND = 32'hDEAD_BEEF; bus.DIVISOR = 32'd3;
        wait_done(7, lat, busy, to);
        e = sb.pop_front(); g = '{bus.QUO, bus.REM, bus.DBZ};
        n_checks++;
        if (to || lat != 33) $display("FAIL hs_latency: got %0d timeout=%0b expected 33", lat, to);
        else n_pass++;
        n_checks++;
        if (g !== e) $display("FAIL hs_result: got quo=%h rem=%h expected quo=%h rem=%h",
                              g.quo, g.rem, e.quo, e.rem);
        else n_pass++;
        // START during DONE must be dropped, not queued.
        bus.START = 1'b1; bus.DIVIDEND = 32'd8; bus.DIVISOR = 32'd2;
        @(negedge clk);
        bus.START = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.BUSY !== 1'b0 || bus.QUO !== e.quo)
            $display("FAIL hs_start_in_done: busy=%b quo=%h expected busy=0 quo=%h", bus.BUSY, bus.QUO, e.quo);
        else n_pass++;
        $display("handshake: ignored starts, result quo=%0d rem=%0d", g.quo, g.rem);
    endtask

    task automatic test_back_to_back();
        int lat, busy; bit to; res_t e, g;
        drive_start(32'd1000, 32'd33, 1'b1);
        wait_done(1, lat, busy, to);
        e = sb.pop_front(); g = '{bus.QUO, bus.REM, bus.DBZ};
        n_checks++;
        if (to || g !== e) $display("FAIL b2b_first: got quo=%h rem=%h expected quo=%h rem=%h",
                                    g.quo, g.rem, e.quo, e.rem);
        else n_pass++;
        // Hold START through the DONE cycle; it is accepted on the following edge.
        bus.START = 1'b1; bus.DIVIDEND = 32'd77777; bus.DIVISOR = 32'd123;
        sb.push_back(model(32'd77777, 32'd123));
        @(negedge clk);
        n_checks++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0)
            $display("FAIL b2b_idle_gap: busy=%b done=%b expected 0 0", bus.BUSY, bus.DONE);
        else n_pass++;
        @(negedge clk);
        bus.START = 1'b0; bus.DIVIDEND = $urandom; bus.DIVISOR = $urandom;
        n_checks++;
        if (bus.BUSY !== 1'b1) $display("FAIL b2b_accept: busy=%b expected 1", bus.BUSY);
        else n_pass++;
        wait_done(1, lat, busy, to);
        e = sb.pop_front(); g = '{bus.QUO, bus.REM, bus.DBZ};
        n_checks++;
        if (to || lat != 33 || g !== e)
            $display("FAIL b2b_second: got quo=%h rem=%h lat=%0d expected quo=%h rem=%h lat=33",
                     g.quo, g.rem, lat, e.quo, e.rem);
        else n_pass++;
        $display("back_to_back: 77777/123 -> quo=%0d rem=%0d", g.quo, g.rem);
    endtask

    task automatic test_reset_mid_run();
        int lat, busy; bit to; res_t e, g;
        drive_start(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.QUO, bus.REM, bus.BUSY, bus.DONE, bus.DBZ} !== 67'd0)
            $display("FAIL midrun_reset: got quo=%h rem=%h busy=%b done=%b dbz=%b expected all zero",
                     bus.QUO, bus.REM, bus.BUSY, bus.DONE, bus.DBZ);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.BUSY !== 1'b0) $display("FAIL midrun_idle: busy=%b expected 0", bus.BUSY);
        else n_pass++;
        drive_start(32'd100, 32'd7, 1'b1);
        wait_done(1, lat, busy, to);
        e = sb.pop_front(); g = '{bus.QUO, bus.REM, bus.DBZ};
        n_checks++;
        if (to || g !== e) $display("FAIL midrun_after: got quo=%h rem=%h expected quo=%h rem=%h",
                                    g.quo, g.rem, e.quo, e.rem);
        else n_pass++;
        $display("reset_mid_run: after release 100/7 -> quo=%0d rem=%0d", g.quo, g.rem);
    endtask

    task automatic test_random();
        int lat, busy; bit to; res_t e, g, prev;
        logic [31:0] a, b;
        int bad = 0;
        prev = '{bus.QUO, bus.REM, bus.DBZ};
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom_range(255, 1);
                1: b = $urandom | 32'h8000_0000;
                2: b = $urandom >> $urandom_range(31, 0);
                default: b = $urandom;
            endcase
            if (b == 32'd0) b = 32'd1;
            drive_start(a, b, 1'b1);
            n_checks++;
            if (bus.QUO !== prev.quo || bus.REM !== prev.rem) begin
                $display("FAIL rand_hold: got quo=%h rem=%h expected quo=%h rem=%h",
                         bus.QUO, bus.REM, prev.quo, prev.rem);
                bad++;
            end else n_pass++;
            wait_done(1, lat, busy, to);
            e = sb.pop_front(); g = '{bus.QUO, bus.REM, bus.DBZ};
            n_checks++;
            if (to || lat != 33 || g !== e) begin
                $display("FAIL rand_result: %h/%h got quo=%h rem=%h lat=%0d expected quo=%h rem=%h lat=33",
                         a, b, g.quo, g.rem, lat, e.quo, e.rem);
                bad++;
            end else n_pass++;
            $display("random %0d: %h/%h -> quo=%h rem=%h", i, a, b, g.quo, g.rem);
            prev = e;
        end
        $display("random: %0d ops, %0d bad", 1000, bad);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_large();
        test_dbz();
        test_handshake();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
